// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response and decode handshake bundle for the fetch stage.
// master = fetch stage, slave = memory + decode side.
interface ifu_fetch_if #(
    parameter int unsigned CPU_WIDTH = 64
) ();
    logic                 imem_req_valid;
    logic [CPU_WIDTH-1:0] imem_req_addr;
    logic                 imem_req_ready;
    logic                 imem_resp_valid;
    logic [31:0]          imem_resp_data;
    logic                 id_valid;
    logic                 id_ready;
    logic [CPU_WIDTH-1:0] id_pc;
    logic [31:0]          id_inst;
    logic                 id_misalign;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output id_valid, id_pc, id_inst, id_misalign,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  id_valid, id_pc, id_inst, id_misalign,
        output id_ready
    );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem read at a time and
// presents {pc, inst} to decode; redirects kill in-flight or held fetches.
module ifu_fetch #(
    parameter int unsigned          CPU_WIDTH = 64,
    parameter logic [CPU_WIDTH-1:0] RESET_PC  = 64'h8000_0000,
    parameter logic [31:0]          NOP_INST  = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_en,
    input  logic [CPU_WIDTH-1:0] pc_next,
    input  logic                 pc_redirect,
    output logic [CPU_WIDTH-1:0] curr_pc,
    ifu_fetch_if.master          bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_e;

    state_e               state_q, state_d;
    logic                 kill_q, kill_d;
    logic [CPU_WIDTH-1:0] curr_pc_q, curr_pc_d;
    logic [CPU_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [CPU_WIDTH-1:0] id_pc_q, id_pc_d;
    logic [31:0]          id_inst_q, id_inst_d;
    logic                 id_misalign_q, id_misalign_d;

    always_comb begin
        state_d       = state_q;
        kill_d        = kill_q;
        curr_pc_d     = curr_pc_q;
        req_addr_d    = req_addr_q;
        id_pc_d       = id_pc_q;
        id_inst_d     = id_inst_q;
        id_misalign_d = id_misalign_q;

        case (state_q)
            ST_IDLE: begin
                if (fetch_en) begin
                    if (curr_pc_q[1:0] != 2'b00) begin
                        state_d       = ST_HOLD;
                        id_pc_d       = curr_pc_q;
                        id_inst_d     = NOP_INST;
                        id_misalign_d = 1'b1;
                    end else begin
                        state_d    = ST_REQ;
                        req_addr_d = curr_pc_q;
                    end
                end
            end
            ST_REQ: begin
                if (bus.imem_req_ready) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.imem_resp_valid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        id_pc_d       = curr_pc_q;
                        id_inst_d     = bus.imem_resp_data;
                        id_misalign_d = 1'b0;
                        state_d       = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.id_ready) begin
                    curr_pc_d = pc_next;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Redirect overrides the normal transitions; a stalled request keeps its
        // latched address (req_addr_q) so it still completes and is then drained.
        if (pc_redirect) begin
            curr_pc_d = pc_next;
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_REQ:  kill_d  = 1'b1;
                ST_WAIT: begin
                    if (bus.imem_resp_valid) begin
                        state_d       = ST_IDLE;
                        kill_d        = 1'b0;
                        id_pc_d       = id_pc_q;
                        id_inst_d     = id_inst_q;
                        id_misalign_d = id_misalign_q;
                    end else begin
                        kill_d = 1'b1;
                    end
                end
                ST_HOLD: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            kill_q        <= 1'b0;
            curr_pc_q     <= RESET_PC;
            req_addr_q    <= '0;
            id_pc_q       <= '0;
            id_inst_q     <= '0;
            id_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            kill_q        <= kill_d;
            curr_pc_q     <= curr_pc_d;
            req_addr_q    <= req_addr_d;
            id_pc_q       <= id_pc_d;
            id_inst_q     <= id_inst_d;
            id_misalign_q <= id_misalign_d;
        end
    end

    assign curr_pc            = curr_pc_q;
    assign bus.imem_req_valid = (state_q == ST_REQ);
    assign bus.imem_req_addr  = req_addr_q;
    assign bus.id_valid       = (state_q == ST_HOLD);
    assign bus.id_pc          = id_pc_q;
    assign bus.id_inst        = id_inst_q;
    assign bus.id_misalign    = id_misalign_q;
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: memory responder plus decode scoreboard; expected
// request addresses and decode outputs are queued by the stimulus.
module tb_ifu_fetch;
    localparam int unsigned W = 64;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic        mis;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_en = 1'b0;
    logic        pc_redirect = 1'b0;
    logic [63:0] pc_next = '0;
    logic [63:0] curr_pc;

    out_t        exp_q[$];
    logic [63:0] addr_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          n_pop = 0;
    int          stall_cnt = 0;
    int          resp_delay = 0;
    int          target;

    ifu_fetch_if #(.CPU_WIDTH(W)) bus ();

    ifu_fetch #(
        .CPU_WIDTH(W),
        .RESET_PC (64'h8000_0000),
        .NOP_INST (32'h0000_0013)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_en   (fetch_en),
        .pc_next    (pc_next),
        .pc_redirect(pc_redirect),
        .curr_pc    (curr_pc),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_for(input logic [63:0] a);
        return 32'h0010_0093 | {a[11:2], 22'h0};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        pc_next = curr_pc + 64'd4;
    endtask

    task automatic wait_pops(input int tgt, input string tag);
        for (int i = 0; i < 100 && n_pop < tgt; i++) cyc();
        chk(tag, n_pop, tgt);
    endtask

    task automatic wait_id_valid(input string tag);
        for (int i = 0; i < 100 && !bus.id_valid; i++) cyc();
        chk(tag, bus.id_valid, 1);
    endtask

    task automatic redirect(input logic [63:0] tgt);
        pc_redirect = 1'b1;
        pc_next     = tgt;
        cyc();
        pc_redirect = 1'b0;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        fetch_en    = 1'b0;
        pc_redirect = 1'b0;
        cyc();
        cyc();
    endtask

    // Memory model: ready gated by stall_cnt, one response resp_delay cycles after accept.
    initial begin
        bit          busy;
        int          cnt;
        logic [63:0] raddr;
        busy = 1'b0;
        cnt = 0;
        raddr = '0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            bus.imem_resp_valid = 1'b0;
            if (rst) begin
                busy = 1'b0;
                bus.imem_req_ready = 1'b0;
            end else begin
                if (busy) begin
                    if (cnt == 0) begin
                        bus.imem_resp_valid = 1'b1;
                        bus.imem_resp_data  = inst_for(raddr);
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                bus.imem_req_ready = (stall_cnt == 0);
                if (bus.imem_req_valid) begin
                    if (stall_cnt > 0) begin
                        stall_cnt--;
                    end else begin
                        if (addr_q.size() == 0) chk("req_unexpected", addr_q.size(), 1);
                        else chk("req_addr", bus.imem_req_addr, addr_q.pop_front());
                        busy  = 1'b1;
                        cnt   = resp_delay;
                        raddr = bus.imem_req_addr;
                    end
                end
            end
        end
    end

    // Decode side scoreboard: compare every fired instruction against the queue.
    initial begin
        out_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.id_valid && bus.id_ready) begin
                if (exp_q.size() == 0) begin
                    chk("id_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("id_pc", bus.id_pc, e.pc);
                    chk("id_inst", {32'h0, bus.id_inst}, {32'h0, e.inst});
                    chk("id_misalign", bus.id_misalign, e.mis);
                end
                n_pop++;
            end
        end
    end

    initial begin
        bus.id_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst_curr_pc", curr_pc, 64'h8000_0000);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_id_valid", bus.id_valid, 0);
        chk("rst_id_pc", bus.id_pc, 0);
        chk("rst_id_inst", {32'h0, bus.id_inst}, 0);
        chk("rst_id_misalign", bus.id_misalign, 0);
        rst = 1'b0;

        // Sequential fetch, zero-wait memory
        addr_q.push_back(64'h8000_0000);
        addr_q.push_back(64'h8000_0004);
        exp_q.push_back('{pc: 64'h8000_0000, inst: inst_for(64'h8000_0000), mis: 1'b0});
        exp_q.push_back('{pc: 64'h8000_0004, inst: inst_for(64'h8000_0004), mis: 1'b0});
        fetch_en = 1'b1;
        cyc();
        chk("lat_req_valid", bus.imem_req_valid, 1);
        cyc();
        chk("lat_id_valid_early", bus.id_valid, 0);
        cyc();
        chk("lat_id_valid", bus.id_valid, 1);
        wait_pops(2, "seq_pops");
        fetch_en = 1'b0;
        chk("seq_curr_pc", curr_pc, 64'h8000_0008);

        // Request stall then decode stall
        do_reset();
        rst = 1'b0;
        stall_cnt = 3;
        bus.id_ready = 1'b0;
        addr_q.push_back(64'h8000_0000);
        exp_q.push_back('{pc: 64'h8000_0000, inst: inst_for(64'h8000_0000), mis: 1'b0});
        fetch_en = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("stall_req_valid", bus.imem_req_valid, 1);
            chk("stall_req_addr", bus.imem_req_addr, 64'h8000_0000);
            cyc();
        end
        chk("after_accept_req_valid", bus.imem_req_valid, 0);
        wait_id_valid("hold_reach");
        for (int i = 0; i < 5; i++) begin
            chk("hold_id_valid", bus.id_valid, 1);
            chk("hold_id_pc", bus.id_pc, 64'h8000_0000);
            chk("hold_id_inst", {32'h0, bus.id_inst}, {32'h0, inst_for(64'h8000_0000)});
            chk("hold_curr_pc", curr_pc, 64'h8000_0000);
            cyc();
        end
        bus.id_ready = 1'b1;
        target = n_pop + 1;
        wait_pops(target, "hold_pops");
        fetch_en = 1'b0;
        chk("hold_fire_curr_pc", curr_pc, 64'h8000_0004);

        // Redirect while waiting for a slow response
        resp_delay = 3;
        addr_q.push_back(64'h8000_0004);
        addr_q.push_back(64'h8000_0100);
        exp_q.push_back('{pc: 64'h8000_0100, inst: inst_for(64'h8000_0100), mis: 1'b0});
        fetch_en = 1'b1;
        cyc();
        cyc();
        chk("wait_req_valid", bus.imem_req_valid, 0);
        redirect(64'h8000_0100);
        resp_delay = 0;
        chk("wait_redirect_pc", curr_pc, 64'h8000_0100);
        chk("wait_redirect_id_valid", bus.id_valid, 0);
        target = n_pop + 1;
        wait_pops(target, "kill_pops");
        fetch_en = 1'b0;

        // Misaligned redirect target: NOP with misalign flag, no memory request
        redirect(64'h8000_0102);
        chk("mis_curr_pc", curr_pc, 64'h8000_0102);
        exp_q.push_back('{pc: 64'h8000_0102, inst: 32'h0000_0013, mis: 1'b1});
        fetch_en = 1'b1;
        cyc();
        chk("mis_id_valid", bus.id_valid, 1);
        chk("mis_id_misalign", bus.id_misalign, 1);
        chk("mis_id_inst", {32'h0, bus.id_inst}, 64'h13);
        chk("mis_req_valid", bus.imem_req_valid, 0);
        target = n_pop + 1;
        wait_pops(target, "mis_pops");
        fetch_en = 1'b0;

        // Redirect coincident with fire in HOLD
        redirect(64'h8000_0200);
        addr_q.push_back(64'h8000_0200);
        exp_q.push_back('{pc: 64'h8000_0200, inst: inst_for(64'h8000_0200), mis: 1'b0});
        bus.id_ready = 1'b0;
        fetch_en = 1'b1;
        wait_id_valid("coin_hold");
        fetch_en = 1'b0;
        target = n_pop + 1;
        bus.id_ready = 1'b1;
        redirect(64'h8000_0300);
        chk("coin_pops", n_pop, target);
        chk("coin_curr_pc", curr_pc, 64'h8000_0300);
        chk("coin_id_valid", bus.id_valid, 0);
        addr_q.push_back(64'h8000_0300);
        exp_q.push_back('{pc: 64'h8000_0300, inst: inst_for(64'h8000_0300), mis: 1'b0});
        fetch_en = 1'b1;
        target = n_pop + 1;
        wait_pops(target, "coin_next_pops");
        fetch_en = 1'b0;

        repeat (5) cyc();
        chk("exp_q_drained", exp_q.size(), 0);
        chk("addr_q_drained", addr_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch stage: owns the architectural fetch PC register, issues one instruction-memory read per PC, and presents the fetched 32-bit instruction with its PC to decode over a valid/ready handshake. It sits directly downstream of the next-PC select logic. It consumes that logic's next-PC value and its taken-redirect flag, and feeds its current PC back to it. At most one memory request is outstanding; redirects kill in-flight or buffered fetches.

## Interface
- `CPU_WIDTH`, 64: PC / address width.
- `RESET_PC`, 64'h8000_0000: PC loaded on reset.
- `NOP_INST`, 32'h0000_0013: instruction presented with a misalign flag.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fetch_en`  in  1  permits new requests; low keeps FSM in IDLE.
- `pc_next`  in  CPU_WIDTH  next PC from PC select logic.
- `pc_redirect`  in  1  taken branch/jump; `pc_next` is a redirect target.
- `curr_pc`  out  CPU_WIDTH  current fetch PC, fed back to PC select.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_addr`  out  CPU_WIDTH  read address (= `curr_pc`).
- `imem_req_ready`  in  1  memory accepts request.
- `imem_resp_valid`  in  1  read data valid (1-cycle pulse per request).
- `imem_resp_data`  in  32  instruction word.
- `id_valid`  out  1  instruction valid to decode.
- `id_ready`  in  1  decode accepts.
- `id_pc`  out  CPU_WIDTH  PC of presented instruction.
- `id_inst`  out  32  presented instruction.
- `id_misalign`  out  1  presented PC has `[1:0] != 0`.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Register `kill` (1 bit).
- IDLE: `fetch_en` -> REQ, or -> HOLD directly with `id_inst=NOP_INST`, `id_misalign=1` if `curr_pc[1:0]!=0`. No memory request is made for a misaligned PC.
- REQ: `imem_req_valid=1`, `imem_req_addr=curr_pc`; address and valid stay stable until `imem_req_ready`. Accept -> WAIT.
- WAIT: on `imem_resp_valid`:
  - if `kill`: discard data, clear `kill`, go IDLE;
  - else: capture `{curr_pc, imem_resp_data}` into output register, go HOLD.
- HOLD: `id_valid=1`. On `id_valid & id_ready` (fire): `curr_pc <= pc_next`, go IDLE.
- `pc_redirect` (any state), highest priority:
  - `curr_pc <= pc_next`;
  - REQ, not accepted this cycle: request still completes with old address; set `kill`, go WAIT on accept.
  - REQ accepted this cycle, or WAIT without response: set `kill`.
  - WAIT with response same cycle: discard it, go IDLE.
  - HOLD: drop output (`id_valid` low next cycle), go IDLE. If fire occurs in the same cycle, decode still takes the instruction.
- `kill` never blocks a later request. The response of the killed request is always drained before a new one is issued.
- `pc_next` is sampled only on fire or redirect; otherwise `curr_pc` holds.

## Timing
- Reset values: `curr_pc=RESET_PC`, state IDLE, `kill=0`, `imem_req_valid=0`, `id_valid=0`, `id_pc=0`, `id_inst=0`, `id_misalign=0`.
- Minimum latency: IDLE -> REQ (1) -> WAIT (accept, 1) -> HOLD (response, ≥1). `id_valid` rises 3 cycles after leaving IDLE with zero-wait memory.
- Throughput: one instruction per 4 cycles best case. No overlap by design.
- All outputs are registered except `imem_req_valid`, `imem_req_addr`, and `id_valid`, which are decoded from state and registers only.
- Responses arriving outside WAIT are ignored.
- `rst` mid-transaction returns to reset values. The response of an outstanding request arriving after reset is ignored, because the state is IDLE/REQ, not WAIT.

## Test plan
- Reset, `fetch_en=1`, zero-wait memory returning `0x00100093`, `id_ready=1`, `pc_next=curr_pc+4`: requests at 0x80000000, then 0x80000004; each `id_valid` pulse carries the matching PC and instruction.
- Memory holds `imem_req_ready=0` for 3 cycles: `imem_req_valid` and `imem_req_addr=0x80000000` stay stable; WAIT entered only after accept.
- `id_ready=0` for 5 cycles in HOLD: `id_valid`, `id_pc`, and `id_inst` stay stable; `curr_pc` stays unchanged until fire.
- `pc_redirect=1`, `pc_next=0x80000100` while in WAIT: late response discarded (no `id_valid`); next request address is 0x80000100.
- Redirect to 0x80000102: no memory request; `id_valid=1`, `id_inst=0x00000013`, `id_misalign=1`, `id_pc=0x80000102`.
- Redirect coincident with HOLD fire: decode receives the held instruction once, and the next request address equals the redirect target.
